// File: rtl/stage_pkg.sv
// Shared drain-state encoding and default sizing for the BRAM staging FIFO.
package stage_pkg;

   localparam int DEF_DATA_W      = 256;
   localparam int DEF_ADDR_W      = 9;
   localparam int DEF_BURST_LEN   = 64;
   localparam int DEF_FULL_MARGIN = 2;
   localparam int OVF_CNT_W       = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } drain_state_t;

endpackage

// File: rtl/stage_sdp_ram.sv
// Simple dual-port RAM: one write port, one enabled registered read port.
module stage_sdp_ram
   import stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/bram_stage_fifo.sv
// BRAM staging FIFO: DRAM words in, fixed-length bursts out with flush.
// Define STAGE_OVF_COUNT_EN to add the saturating ovf_count output.
module bram_stage_fifo
   import stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int BURST_LEN   = DEF_BURST_LEN,
   parameter int FULL_MARGIN = DEF_FULL_MARGIN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              bram_full,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [ADDR_W:0]   level,
   output logic              overflow
`ifdef STAGE_OVF_COUNT_EN
   ,
   output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] BURST_L = (ADDR_W+1)'(BURST_LEN);
   localparam logic [ADDR_W:0] FULL_L  = (ADDR_W+1)'(DEPTH - FULL_MARGIN);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   drain_state_t      state;
   drain_state_t      state_n;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level_n;
   logic [ADDR_W:0]   beats;
   logic [ADDR_W:0]   beats_n;
   logic [ADDR_W:0]   fetch_left;
   logic [ADDR_W:0]   fetch_left_n;
   logic              flush_pend;
   logic              flush_burst;
   logic              flush_burst_n;
   logic              flush_clr;
   logic              rd_valid;
   logic [DATA_W-1:0] ram_rdata;
   logic              wr_ok;
   logic              drop;
   logic              hs;
   logic              move;
   logic              fetch;

   assign wr_ok = wr_en & (level != DEPTH_L);
   assign drop  = wr_en & (level == DEPTH_L);
   assign hs    = out_valid & out_ready;
   // RAM read register hands its word to the output register
   assign move  = rd_valid & (~out_valid | out_ready);

   assign out_last = out_valid & (beats == ONE);
   assign level_n  = level + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(hs);

   stage_sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .re    (fetch),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_n       = state;
      beats_n       = beats;
      fetch_left_n  = fetch_left;
      flush_burst_n = flush_burst;
      flush_clr     = 1'b0;
      fetch         = 1'b0;
      unique case (state)
         IDLE: begin
            if (level >= BURST_L) begin
               state_n       = STREAM;
               beats_n       = BURST_L;
               fetch_left_n  = BURST_L;
               flush_burst_n = 1'b0;
            end else if (flush_pend && level != '0) begin
               state_n       = STREAM;
               beats_n       = level;
               fetch_left_n  = level;
               flush_burst_n = 1'b1;
            end else if (flush_pend) begin
               flush_clr = 1'b1;
            end
         end
         STREAM: begin
            // two-stage pipe: fetch only when the read register frees up
            fetch = (fetch_left != '0) && (!rd_valid || move);
            if (fetch)
               fetch_left_n = fetch_left - ONE;
            if (hs) begin
               beats_n = beats - ONE;
               if (beats == ONE) begin
                  state_n   = GAP;
                  flush_clr = flush_burst;
               end
            end
         end
         GAP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         beats       <= '0;
         fetch_left  <= '0;
         flush_pend  <= 1'b0;
         flush_burst <= 1'b0;
         rd_valid    <= 1'b0;
         out_valid   <= 1'b0;
         bram_full   <= 1'b0;
      end else begin
         state       <= state_n;
         beats       <= beats_n;
         fetch_left  <= fetch_left_n;
         flush_burst <= flush_burst_n;
         flush_pend  <= flush | (flush_pend & ~flush_clr);
         level       <= level_n;
         bram_full   <= (level >= FULL_L);
         rd_valid    <= fetch | (rd_valid & ~move);
         out_valid   <= move | (out_valid & ~hs);
         if (wr_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (fetch)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (move)
         out_data <= ram_rdata;
   end

`ifdef STAGE_OVF_COUNT_EN
   localparam logic [OVF_CNT_W-1:0] CNT_ONE = OVF_CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_count <= '0;
      else if (drop && ovf_count != '1)
         ovf_count <= ovf_count + CNT_ONE;
   end

   assign overflow = (ovf_count != '0);
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end
`endif

endmodule
